// File: rtl/lamp_controller.sv
// Lamp controller: decodes command edges into on/off/toggle, holds lamp state, auto-off timer.
// Define LAMP_WARN_EN to compile in the blinking WARN phase between ON expiry and OFF.
module lamp_controller #(
    parameter int TIMEOUT     = 16,
    parameter int WARN_CYCLES = 8,
    parameter int BLINK_LOG2  = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] cmd,
    input  logic       presence,
    output logic       lamp,
    output logic       warn,
    output logic [1:0] state
);

    localparam int MAX_CYC = (TIMEOUT > WARN_CYCLES) ? TIMEOUT : WARN_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] ON_LOAD = CNT_W'(TIMEOUT - 1);
`ifdef LAMP_WARN_EN
    localparam logic [CNT_W-1:0] WARN_LOAD = CNT_W'(WARN_CYCLES - 1);
`endif

    localparam logic [1:0] CMD_NONE   = 2'b00;
    localparam logic [1:0] CMD_ON     = 2'b01;
    localparam logic [1:0] CMD_OFF    = 2'b10;
    localparam logic [1:0] CMD_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_ON   = 2'b01,
        ST_WARN = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cmd_q, cmd_d;
    logic             cmd_evt;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        cmd_d   = cmd;
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_evt = (cmd != cmd_q) && (cmd != CMD_NONE);

        case (state_q)
            ST_OFF: begin
                if (cmd_evt && (cmd == CMD_ON || cmd == CMD_TOGGLE)) begin
                    state_d = ST_ON;
                    cnt_d   = ON_LOAD;
                end
            end

            ST_ON: begin
                if (cmd_evt) begin
                    if (cmd == CMD_ON) begin
                        cnt_d = ON_LOAD;
                    end else begin
                        state_d = ST_OFF;
                    end
                end else if (presence) begin
                    cnt_d = ON_LOAD;
                end else if (cnt_q == '0) begin
`ifdef LAMP_WARN_EN
                    state_d = ST_WARN;
                    cnt_d   = WARN_LOAD;
`else
                    state_d = ST_OFF;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

`ifdef LAMP_WARN_EN
            ST_WARN: begin
                if (cmd_evt) begin
                    if (cmd == CMD_ON) begin
                        state_d = ST_ON;
                        cnt_d   = ON_LOAD;
                    end else begin
                        state_d = ST_OFF;
                    end
                end else if (presence) begin
                    state_d = ST_ON;
                    cnt_d   = ON_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = ST_OFF;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif

            // Encoding 11 (and WARN when not compiled in) falls back to OFF.
            default: state_d = ST_OFF;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            cmd_q   <= CMD_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
        end
    end

    // Outputs decode registered state only, so reset clears them without waiting for an edge.
    assign state = state_q;
    assign lamp  = (state_q == ST_ON) || ((state_q == ST_WARN) && cnt_q[BLINK_LOG2]);
`ifdef LAMP_WARN_EN
    assign warn  = (state_q == ST_WARN);
`else
    assign warn  = 1'b0;
`endif

endmodule

// File: tb/tb_lamp_controller.sv
// Directed self-checking bench for lamp_controller (TIMEOUT=8, WARN_CYCLES=4, BLINK_LOG2=1).
// Follows LAMP_WARN_EN to pick the expiry behaviour it expects.
module tb_lamp_controller;

    logic       clock;
    logic       reset;
    logic [1:0] cmd;
    logic       presence;
    logic       lamp;
    logic       warn;
    logic [1:0] state;

    int n_checks = 0;
    int n_errors = 0;

    localparam int S_OFF  = 0;
    localparam int S_ON   = 1;
    localparam int S_WARN = 2;

    lamp_controller #(
        .TIMEOUT    (8),
        .WARN_CYCLES(4),
        .BLINK_LOG2 (1)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .cmd     (cmd),
        .presence(presence),
        .lamp    (lamp),
        .warn    (warn),
        .state   (state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_out(input string tag, input int exp_state, input int exp_lamp, input int exp_warn);
        check({tag, ".state"}, int'(state), exp_state);
        check({tag, ".lamp"},  int'(lamp),  exp_lamp);
        check({tag, ".warn"},  int'(warn),  exp_warn);
    endtask

    // Reset with cmd idle, release just after an edge; DUT is then OFF with cmd_q=00.
    task automatic do_reset();
        reset    = 1'b1;
        cmd      = 2'b00;
        presence = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Turn on with cmd=01, return cmd to 00; returns in ON cycle 0 (counter 7).
    task automatic go_on();
        cmd = 2'b01;
        tick();
        cmd = 2'b00;
    endtask

    initial begin
        int blink_exp[4];
        blink_exp = '{1, 1, 0, 0};

        // Reset and power-on: command held during reset is ignored, then fires on release.
        reset    = 1'b1;
        cmd      = 2'b01;
        presence = 1'b0;
        tick(2);
        check_out("reset_hold", S_OFF, 0, 0);
        reset = 1'b0;
        tick();
        check_out("power_on", S_ON, 1, 0);

        // Toggle edge detection.
        do_reset();
        cmd = 2'b11;
        tick();
        check_out("toggle_first", S_ON, 1, 0);
        tick(5);
        check_out("toggle_held", S_ON, 1, 0);
        cmd = 2'b00;
        tick();
        cmd = 2'b11;
        tick();
        check_out("toggle_second", S_OFF, 0, 0);
        cmd = 2'b00;

        // Timeout: exactly 8 ON cycles, then WARN blinking 1,1,0,0, then OFF.
        do_reset();
        go_on();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("timeout_on%0d", i), int'(state), S_ON);
            tick();
        end
`ifdef LAMP_WARN_EN
        for (int i = 0; i < 4; i++) begin
            check_out($sformatf("warn%0d", i), S_WARN, blink_exp[i], 1);
            tick();
        end
`endif
        check_out("timeout_off", S_OFF, 0, 0);

        // Presence retrigger at cycle 6 extends ON through cycle 14.
        do_reset();
        go_on();
        tick(6);
        presence = 1'b1;
        tick();
        presence = 1'b0;
        check_out("retrig_c7", S_ON, 1, 0);
        tick(7);
        check_out("retrig_c14", S_ON, 1, 0);
        tick();
`ifdef LAMP_WARN_EN
        check_out("retrig_c15", S_WARN, 1, 1);
        presence = 1'b1;
        tick();
        presence = 1'b0;
        check_out("warn_presence", S_ON, 1, 0);
`else
        check_out("retrig_c15", S_OFF, 0, 0);
`endif

        // Toggle in the expiry cycle wins over expiry.
        do_reset();
        go_on();
        tick(7);
        cmd = 2'b11;
        tick();
        check_out("toggle_at_expiry", S_OFF, 0, 0);
        cmd = 2'b00;

        // Presence in the expiry cycle reloads; then on-command at expiry reloads again.
        do_reset();
        go_on();
        tick(7);
        presence = 1'b1;
        tick();
        presence = 1'b0;
        check_out("presence_at_expiry", S_ON, 1, 0);
        tick(7);
        cmd = 2'b01;
        tick();
        check_out("on_at_expiry", S_ON, 1, 0);
        tick(7);
        check_out("on_reload_last", S_ON, 1, 0);
        tick();
`ifdef LAMP_WARN_EN
        check_out("on_reload_expired", S_WARN, 1, 1);
`else
        check_out("on_reload_expired", S_OFF, 0, 0);
`endif
        cmd = 2'b00;

        // Off command while ON.
        do_reset();
        go_on();
        tick(2);
        cmd = 2'b10;
        tick();
        check_out("off_in_on", S_OFF, 0, 0);
        cmd = 2'b00;

`ifdef LAMP_WARN_EN
        // Off command while in WARN.
        do_reset();
        go_on();
        tick(8);
        check_out("enter_warn", S_WARN, 1, 1);
        cmd = 2'b10;
        tick();
        check_out("off_in_warn", S_OFF, 0, 0);
        cmd = 2'b00;

        // Asynchronous reset between edges while in WARN.
        do_reset();
        go_on();
        tick(8);
        #2;
        reset = 1'b1;
        #1;
        check_out("async_reset_warn", S_OFF, 0, 0);
`else
        // Asynchronous reset between edges while in ON.
        do_reset();
        go_on();
        tick(3);
        #2;
        reset = 1'b1;
        #1;
        check_out("async_reset_on", S_OFF, 0, 0);
`endif
        tick();
        reset = 1'b0;
        tick();
        check_out("after_reset", S_OFF, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
